// File: rtl/alu_cmd_if.sv
// alu_cmd_if: command and response valid/ready channels between a host and alu_cmd_driver
interface alu_cmd_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [2:0] rsp_op;
    logic [3:0] rsp_sum;
    logic       rsp_carry;
    logic       rsp_ovf;
    logic       rsp_flag;
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_op, rsp_sum, rsp_carry, rsp_ovf, rsp_flag
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_op, rsp_sum, rsp_carry, rsp_ovf, rsp_flag
    );
endinterface

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: queues ALU commands, drives a combinational ALU and returns captured results
module alu_cmd_driver #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_cmd_if.slave         bus,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_sel,
    input  logic [3:0]       alu_sum,
    input  logic             alu_carry,
    input  logic             alu_ovf,
    input  logic             alu_flag,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic             busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, DRIVE, WAIT} state_t;
    state_t        state, state_nx;
    logic [10:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, capture, empty, full;
    assign empty         = count == '0;
    assign full          = count == (AW+1)'(FIFO_DEPTH);
    assign bus.cmd_ready = rst_n && !full;
    assign push          = bus.cmd_valid && bus.cmd_ready;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = empty ? IDLE : DRIVE;
            DRIVE:   state_nx = WAIT;
            WAIT:    state_nx = !bus.rsp_ready ? WAIT : (empty ? IDLE : DRIVE);
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        pop     = !empty && (state == IDLE || (state == WAIT && bus.rsp_ready));
        capture = state == DRIVE;
        busy    = state != IDLE || !empty;
    end
    // Queue storage carries no reset; occupancy is governed by count alone.
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_sel       <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_op    <= '0;
            bus.rsp_sum   <= '0;
            bus.rsp_carry <= 1'b0;
            bus.rsp_ovf   <= 1'b0;
            bus.rsp_flag  <= 1'b0;
            ovf_cnt       <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr                   <= rd_ptr + AW'(1);
                {alu_sel, alu_a, alu_b}  <= mem[rd_ptr];
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (capture) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_op    <= alu_sel;
                bus.rsp_sum   <= alu_sum;
                bus.rsp_carry <= alu_carry;
                bus.rsp_ovf   <= alu_ovf;
                bus.rsp_flag  <= alu_flag;
                if (alu_sel[2:1] == 2'b00 && alu_ovf && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
            end else if (state == WAIT && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
            end
        end
endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: directed and random checks of alu_cmd_driver against a queue-based result model
module tb_alu_cmd_driver;
    localparam int CW      = 2;
    localparam int CNT_MAX = (1 << CW) - 1;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    alu_a, alu_b, alu_sum;
    logic [2:0]    alu_sel;
    logic          alu_carry, alu_ovf, alu_flag, busy;
    logic [CW-1:0] ovf_cnt;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            accepted = 0;
    int            ovf_model = 0;
    logic [9:0]    exp_q[$];
    int            rise_q[$];
    alu_cmd_if bus();
    alu_cmd_driver #(.FIFO_DEPTH(4), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_sum(alu_sum), .alu_carry(alu_carry), .alu_ovf(alu_ovf), .alu_flag(alu_flag),
        .ovf_cnt(ovf_cnt), .busy(busy)
    );
    always #5 clk = ~clk;
    // Bit-level stand-in for the team ALU
    always_comb begin
        {alu_carry, alu_sum} = 5'd0;
        alu_ovf  = 1'b0;
        alu_flag = 1'b0;
        case (alu_sel)
            3'd0: begin
                {alu_carry, alu_sum} = {1'b0, alu_a} + {1'b0, alu_b};
                alu_ovf = (alu_a[3] == alu_b[3]) && (alu_sum[3] != alu_a[3]);
            end
            3'd1: begin
                {alu_carry, alu_sum} = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
                alu_ovf = (alu_a[3] != alu_b[3]) && (alu_sum[3] != alu_a[3]);
            end
            3'd2: alu_sum = ~alu_a;
            3'd3: alu_sum = alu_a & alu_b;
            3'd4: alu_sum = alu_a | alu_b;
            3'd5: alu_sum = alu_a ^ alu_b;
            3'd6: alu_flag = $signed(alu_a) < $signed(alu_b);
            default: alu_flag = alu_a == alu_b;
        endcase
    end
    // Expected response {op, sum, carry, ovf, flag} from integer arithmetic
    function automatic logic [9:0] ref_rsp(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int ua = int'(a);
        int ub = int'(b);
        int sa = ua > 7 ? ua - 16 : ua;
        int sb = ub > 7 ? ub - 16 : ub;
        int r = 0;
        logic c = 1'b0, v = 1'b0, f = 1'b0;
        case (op)
            3'd0: begin r = ua + ub; c = r > 15; v = (sa + sb > 7) || (sa + sb < -8); end
            3'd1: begin r = ua - ub; c = ua >= ub; v = (sa - sb > 7) || (sa - sb < -8); end
            3'd2: r = 15 - ua;
            3'd3: r = int'(a & b);
            3'd4: r = int'(a | b);
            3'd5: r = int'(a ^ b);
            3'd6: f = sa < sb;
            default: f = ua == ub;
        endcase
        return {op, 4'((r + 16) % 16), c, v, f};
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic set_cmd(input logic v, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
    endtask
    // One clock: account handshakes seen before the edge, then check after it
    task automatic tick();
        logic was_valid;
        if (bus.cmd_valid && bus.cmd_ready) begin
            exp_q.push_back(ref_rsp(bus.cmd_op, bus.cmd_a, bus.cmd_b));
            accepted++;
        end
        if (bus.rsp_valid) begin
            if (exp_q.size() == 0) chk("stale_rsp", 32'(bus.rsp_valid), 0);
            else begin
                chk("rsp", {22'd0, bus.rsp_op, bus.rsp_sum, bus.rsp_carry, bus.rsp_ovf, bus.rsp_flag}, {22'd0, exp_q[0]});
                if (bus.rsp_ready) void'(exp_q.pop_front());
            end
        end
        was_valid = bus.rsp_valid;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.rsp_valid && !was_valid) begin
            rise_q.push_back(cyc);
            if (exp_q.size() > 0 && exp_q[0][9:8] == 2'b00 && exp_q[0][1])
                ovf_model = ovf_model == CNT_MAX ? CNT_MAX : ovf_model + 1;
        end
        chk("ovf_cnt", 32'(ovf_cnt), ovf_model);
    endtask
    task automatic drain();
        int n = 0;
        bus.rsp_ready = 1'b1;
        while ((exp_q.size() > 0 || busy) && n < 60) begin
            tick();
            n++;
        end
        chk("drain_busy", 32'(busy), 0);
        chk("drain_left", exp_q.size(), 0);
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf_cnt", 32'(ovf_cnt), 0);
        chk("rst_alu", {21'd0, alu_sel, alu_a, alu_b}, 0);
        chk("rst_rsp", {22'd0, bus.rsp_op, bus.rsp_sum, bus.rsp_carry, bus.rsp_ovf, bus.rsp_flag}, 0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
        exp_q.delete();
        ovf_model = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 1);
    endtask
    initial begin
        int sat_exp[5] = '{1, 2, 3, 3, 3};
        set_cmd(1'b0, 3'd0, 4'd0, 4'd0);
        bus.rsp_ready = 1'b0;
        #2;
        do_reset();
        // Single add: 2-cycle latency, signed overflow counted
        bus.rsp_ready = 1'b1;
        set_cmd(1'b1, 3'd0, 4'd7, 4'd1);
        tick();
        set_cmd(1'b0, 3'd0, 4'd0, 4'd0);
        tick();
        chk("add_lat1_valid", 32'(bus.rsp_valid), 0);
        chk("add_alu_a", 32'(alu_a), 7);
        tick();
        chk("add_lat2_valid", 32'(bus.rsp_valid), 1);
        chk("add_sum", 32'(bus.rsp_sum), 8);
        chk("add_carry", 32'(bus.rsp_carry), 0);
        chk("add_ovf", 32'(bus.rsp_ovf), 1);
        chk("add_op", 32'(bus.rsp_op), 0);
        chk("add_ovf_cnt", 32'(ovf_cnt), 1);
        drain();
        // Sub then signed compare, back-to-back
        rise_q.delete();
        set_cmd(1'b1, 3'd1, 4'd3, 4'd5);
        tick();
        set_cmd(1'b1, 3'd6, 4'd3, 4'd5);
        tick();
        set_cmd(1'b0, 3'd0, 4'd0, 4'd0);
        tick();
        chk("sub_sum", 32'(bus.rsp_sum), 32'hE);
        chk("sub_ovf", 32'(bus.rsp_ovf), 0);
        tick();
        tick();
        chk("lt_flag", 32'(bus.rsp_flag), 1);
        drain();
        chk("b2b_pulses", rise_q.size(), 2);
        if (rise_q.size() == 2) chk("b2b_spacing", rise_q[1] - rise_q[0], 2);
        // Back-pressure: five accepted, sixth refused, results in order
        bus.rsp_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            set_cmd(1'b1, 3'(3 + (i % 5)), 4'($urandom), 4'($urandom));
            if (i == 5) chk("bp_cmd_ready", 32'(bus.cmd_ready), 0);
            tick();
        end
        set_cmd(1'b0, 3'd0, 4'd0, 4'd0);
        chk("bp_accepted", accepted, 5);
        for (int i = 0; i < 3; i++) tick();
        chk("bp_busy", 32'(busy), 1);
        drain();
        // Equal, xor, not: counter untouched
        set_cmd(1'b1, 3'd7, 4'd9, 4'd9);
        tick();
        set_cmd(1'b0, 3'd0, 4'd0, 4'd0);
        tick();
        tick();
        chk("eq_flag", 32'(bus.rsp_flag), 1);
        drain();
        set_cmd(1'b1, 3'd5, 4'hA, 4'h5);
        tick();
        set_cmd(1'b1, 3'd2, 4'h3, 4'h0);
        tick();
        set_cmd(1'b0, 3'd0, 4'd0, 4'd0);
        tick();
        chk("xor_sum", 32'(bus.rsp_sum), 32'hF);
        tick();
        tick();
        chk("not_sum", 32'(bus.rsp_sum), 32'hC);
        drain();
        chk("logic_ovf_cnt", 32'(ovf_cnt), 1);
        // Saturation of the 2-bit counter
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_cmd(1'b1, 3'd0, 4'd7, 4'd1);
            tick();
            set_cmd(1'b0, 3'd0, 4'd0, 4'd0);
            tick();
            tick();
            chk("sat_ovf_cnt", 32'(ovf_cnt), sat_exp[i]);
            drain();
        end
        // Reset while holding a result with two queued
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_cmd(1'b1, 3'd0, 4'd7, 4'(i + 1));
            tick();
        end
        set_cmd(1'b0, 3'd0, 4'd0, 4'd0);
        tick();
        chk("pre_rst_valid", 32'(bus.rsp_valid), 1);
        #2;
        do_reset();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("no_stale_valid", 32'(bus.rsp_valid), 0);
        chk("no_stale_busy", 32'(busy), 0);
        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            set_cmd(1'($urandom_range(0, 1)), 3'($urandom), 4'($urandom), 4'($urandom));
            bus.rsp_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        set_cmd(1'b0, 3'd0, 4'd0, 4'd0);
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Sequential front end that issues commands to the team's 4-bit combinational ALU. It queues operand/opcode commands from a valid/ready producer, drives the ALU's operand and select inputs from registers, and captures the ALU's result and flags. It returns each captured result to a consumer over a valid/ready response channel and keeps a saturating count of arithmetic overflows. It sits between the host/test logic and the ALU instance; the ALU itself stays purely combinational.

## Interface
- FIFO_DEPTH, 4, command queue entries; power of two, ≥2
- CNT_W, 8, overflow counter width
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  queue can accept; equals queue not full; forced 0 while rst_n=0
- cmd_op  in  3  ALU select: 0 add, 1 sub, 2 not a, 3 and, 4 or, 5 xor, 6 signed less-than, 7 equal
- cmd_a, cmd_b  in  4 each  operands
- alu_a, alu_b  out  4 each  registered operands to ALU
- alu_sel  out  3  registered select to ALU
- alu_sum  in  4  ALU result
- alu_carry  in  1  ALU carry-out (ops 0/1)
- alu_ovf  in  1  ALU signed overflow (ops 0/1)
- alu_flag  in  1  ALU compare result (ops 6/7)
- rsp_valid  out  1  result held
- rsp_ready  in  1  consumer accepts
- rsp_op  out  3  opcode of held result
- rsp_sum  out  4; rsp_carry, rsp_ovf, rsp_flag  out  1 each  captured ALU outputs
- ovf_cnt  out  CNT_W  saturating count of overflowing add/sub results
- busy  out  1  state≠IDLE or queue non-empty

## Operation
- Queue: FIFO of {op,a,b}, FIFO_DEPTH entries, wrapping read/write pointers plus count. Push on cmd_valid&&cmd_ready. cmd_ready deasserts at full; no push on full; simultaneous push and pop allowed at any non-full count.
- FSM states IDLE, DRIVE, WAIT:
  - IDLE: if queue non-empty, pop head into alu_a/alu_b/alu_sel, go to DRIVE; else stay.
  - DRIVE: exactly one cycle with alu_* stable; at its closing edge capture alu_sum/alu_carry/alu_ovf/alu_flag and the op into rsp_*, set rsp_valid, go to WAIT.
  - WAIT: hold all rsp_* stable while rsp_valid&&!rsp_ready. On rsp_valid&&rsp_ready: clear rsp_valid; if queue non-empty, pop the next head in the same edge and go to DRIVE; else go to IDLE.
- alu_* hold their last driven value outside DRIVE; they change only on a pop.
- Captured flags are passed raw: no masking by opcode (the ALU returns 0 for unused flags).
- ovf_cnt: +1 at the capture edge when op∈{0,1} and alu_ovf=1; holds at 2^CNT_W−1 (no wrap). Cleared only by reset.
- Reset (asynchronous, any state, including mid-DRIVE or WAIT): queue empty, state IDLE, pending result discarded. All outputs 0: rsp_*, rsp_valid, alu_a, alu_b, alu_sel, ovf_cnt, busy. cmd_ready is 0 while rst_n=0 and 1 from the first cycle after release.

## Timing
- Command accepted at edge E0 → popped at E1 → result captured and rsp_valid=1 after E2. Minimum latency is 2 cycles.
- Sustained throughput with rsp_ready=1: one result every 2 cycles (DRIVE, WAIT alternate).
- With rsp_ready=0, the FSM stalls in WAIT. Capacity is FIFO_DEPTH queued commands plus 1 held result.
- The path from cmd_valid and rsp_ready to any output is not combinational. cmd_ready depends only on count and rst_n.
- The external ALU path alu_* → alu_sum/flags → rsp_* must close in one cycle.

## Test plan
- Single add, a=7, b=1, op=0 → after 2 cycles rsp_sum=8, rsp_carry=0, rsp_ovf=1, rsp_op=0; ovf_cnt=1.
- Sub and compare, pushed back-to-back with rsp_ready=1: (op1, a=3, b=5) then (op6, a=3, b=5) → rsp_sum=4'hE, rsp_ovf=0; then rsp_flag=1. The two rsp_valid pulses are 2 cycles apart, in order.
- Back-pressure: rsp_ready=0, push 6 commands → 5 accepted, cmd_ready=0 from the 6th attempt. Release rsp_ready → all 5 results return in push order, unchanged while stalled.
- Equal and logic ops: (op7, a=9, b=9) → rsp_flag=1; (op5, a=4'hA, b=4'h5) → rsp_sum=4'hF; (op2, a=4'h3) → rsp_sum=4'hC; ovf_cnt unchanged.
- Saturation: CNT_W=2, issue 5 overflowing adds (7+1) → ovf_cnt reads 1, 2, 3, 3, 3.
- Reset mid-operation: assert rst_n=0 while in WAIT with 2 queued → immediately rsp_valid=0, busy=0, ovf_cnt=0, alu_*=0. After release, cmd_ready=1 and no stale result emerges.
